// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding and baud timing tables.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int BAUD_CNT_W = 14;

  // Full bit period in clocks for each rate select code
  function automatic logic [BAUD_CNT_W-1:0] bit_period(input logic [1:0] sel);
    logic [BAUD_CNT_W-1:0] p;
    case (sel)
      2'b00:   p = 14'd13004;
      2'b01:   p = 14'd652;
      2'b10:   p = 14'd327;
      default: p = 14'd163;
    endcase
    return p;
  endfunction

  // Half bit period, used to land the start-bit sample mid-bit
  function automatic logic [BAUD_CNT_W-1:0] half_period(input logic [1:0] sel);
    logic [BAUD_CNT_W-1:0] h;
    case (sel)
      2'b00:   h = 14'd6502;
      2'b01:   h = 14'd326;
      2'b10:   h = 14'd163;
      default: h = 14'd81;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit synchronizer chain for an asynchronous input, resets to 1 (idle line).
// Latency: STAGES clocks from d to q.
// Backpressure: none; samples every clock.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 / 8E1 frames, mid-bit sampling, parity and framing checks.
// Latency: data_valid pulses one clock after the mid-stop-bit sample.
// Backpressure: none; each byte is presented for one cycle and held on data_out.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [1:0] baud_rate,
  input  logic       parity_en,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  rx_state_t             state;
  logic                  rx_s;
  logic [BAUD_CNT_W-1:0] baud_cnt;
  logic [BAUD_CNT_W-1:0] baud_lim;
  logic [2:0]            bit_cnt;
  logic [1:0]            baud_sel;
  logic                  par_on;
  logic [7:0]            shreg;
  logic                  par_bad;
  logic                  tick;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .rst   (rst),
    .d     (rx_in),
    .q     (rx_s)
  );

  // Sample point: half a bit into START, a full bit everywhere else, using the latched rate
  always_comb begin
    baud_lim = bit_period(baud_sel) - 14'd1;
    if (state == START) begin
      baud_lim = half_period(baud_sel) - 14'd1;
    end
    tick = (baud_cnt == baud_lim);
  end

  // Frame state machine; outputs are registered and pulses last one clock
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      baud_sel   <= 2'b00;
      par_on     <= 1'b0;
      shreg      <= 8'h00;
      par_bad    <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!rx_s) begin
            // Rate and parity mode are frozen for the whole frame
            baud_sel <= baud_rate;
            par_on   <= parity_en;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            baud_cnt <= '0;
            // A line already back high mid-start-bit is a glitch
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 14'd1;
          end
        end
        DATA: begin
          if (tick) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              par_bad <= 1'b0;
              state   <= par_on ? PARITY : STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 14'd1;
          end
        end
        PARITY: begin
          if (tick) begin
            baud_cnt <= '0;
            // Even parity: data bits plus parity bit must XOR to zero
            par_bad  <= (^shreg) ^ rx_s;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 14'd1;
          end
        end
        STOP: begin
          if (tick) begin
            baud_cnt <= '0;
            if (rx_s) begin
              data_out   <= shreg;
              parity_err <= par_on & par_bad;
              data_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            baud_cnt <= baud_cnt + 14'd1;
          end
        end
        WAIT_HIGH: begin
          // Hold off until the line recovers so a break is not read as a start bit
          baud_cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [1:0] baud_rate;
  logic       parity_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  always #5 clock = ~clock;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clock      (clock),
    .rst        (rst),
    .rx_in      (rx_in),
    .baud_rate  (baud_rate),
    .parity_en  (parity_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Pulse monitor: counts every cycle a pulse is high and logs delivered bytes
  int         vcount = 0;
  int         fcount = 0;
  logic [7:0] vlog [0:255];
  logic       last_perr = 1'b0;

  always @(negedge clock) begin
    if (data_valid) begin
      vlog[vcount[7:0]] = data_out;
      last_perr = parity_err;
      vcount++;
    end
    if (frame_err) begin
      fcount++;
    end
  end

  typedef struct {
    logic [7:0] dat;
    logic [1:0] baud;
    logic       par_en;
    logic       par_bit;
    logic       flip_baud;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int period(input logic [1:0] b);
    case (b)
      2'b00:   return 13004;
      2'b01:   return 652;
      2'b10:   return 327;
      default: return 163;
    endcase
  endfunction

  task automatic drive_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_present, input logic par_bit,
                            input logic stop_bit, input int p, input logic flip_baud);
    drive_bit(1'b0, p);
    if (flip_baud) baud_rate = ~baud_rate;
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (par_present) drive_bit(par_bit, p);
    drive_bit(stop_bit, p);
  endtask

  initial begin
    int         vb;
    int         fb;
    logic [7:0] prev;

    vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{8'h07, 2'd3, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1};
    vecs[2] = '{8'h07, 2'd3, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0};
    vecs[3] = '{8'h5A, 2'd3, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1};
    vecs[4] = '{8'hC3, 2'd1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0};
    vecs[5] = '{8'h96, 2'd3, 1'b1, 1'b0, 1'b1, 8'h96, 1'b0};

    rst       = 1'b0;
    rx_in     = 1'b1;
    baud_rate = 2'd3;
    parity_en = 1'b0;
    repeat (3) @(negedge clock);
    check("reset data_out",   32'(data_out),   32'h00);
    check("reset data_valid", 32'(data_valid), 32'h0);
    check("reset parity_err", 32'(parity_err), 32'h0);
    check("reset frame_err",  32'(frame_err),  32'h0);
    check("reset busy",       32'(busy),       32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clock);

    // Table of well-formed frames
    for (int k = 0; k < 6; k++) begin
      baud_rate = vecs[k].baud;
      parity_en = vecs[k].par_en;
      vb = vcount;
      fb = fcount;
      send_frame(vecs[k].dat, vecs[k].par_en, vecs[k].par_bit, 1'b1,
                 period(vecs[k].baud), vecs[k].flip_baud);
      repeat (20) @(negedge clock);
      check($sformatf("vec%0d valid count", k), 32'(vcount - vb), 32'd1);
      check($sformatf("vec%0d data_out", k), 32'(vlog[vb[7:0]]), 32'(vecs[k].exp_data));
      check($sformatf("vec%0d parity_err", k), 32'(last_perr), 32'(vecs[k].exp_perr));
      check($sformatf("vec%0d frame_err count", k), 32'(fcount - fb), 32'd0);
      check($sformatf("vec%0d busy idle", k), 32'(busy), 32'd0);
    end

    // Glitch on idle line
    baud_rate = 2'd3;
    parity_en = 1'b0;
    vb = vcount;
    fb = fcount;
    drive_bit(1'b0, 10);
    check("glitch busy during", 32'(busy), 32'd1);
    drive_bit(1'b0, 30);
    drive_bit(1'b1, 200);
    check("glitch busy after", 32'(busy), 32'd0);
    check("glitch valid count", 32'(vcount - vb), 32'd0);
    check("glitch frame_err count", 32'(fcount - fb), 32'd0);

    // Framing error with the line stuck low afterwards
    prev = data_out;
    vb = vcount;
    fb = fcount;
    drive_bit(1'b0, 163);
    for (int i = 0; i < 8; i++) drive_bit(prev[i] ^ prev[i] ^ (8'h3C >> i) & 1'b1, 163);
    drive_bit(1'b0, 163 + 500);
    check("ferr frame_err count", 32'(fcount - fb), 32'd1);
    check("ferr valid count", 32'(vcount - vb), 32'd0);
    check("ferr busy while low", 32'(busy), 32'd1);
    drive_bit(1'b1, 10);
    check("ferr busy after high", 32'(busy), 32'd0);
    check("ferr data_out held", 32'(data_out), 32'(prev));
    drive_bit(1'b1, 200);

    // Back-to-back frames at baud_rate 10
    baud_rate = 2'd2;
    vb = vcount;
    fb = fcount;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 327, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 327, 1'b0);
    repeat (20) @(negedge clock);
    check("b2b valid count", 32'(vcount - vb), 32'd2);
    check("b2b first byte",  32'(vlog[vb[7:0]]), 32'h55);
    check("b2b second byte", 32'(vlog[8'(vb + 1)]), 32'hAA);
    check("b2b frame_err count", 32'(fcount - fb), 32'd0);

    // Reset asserted during data bit 4 of 0x81
    baud_rate = 2'd3;
    drive_bit(1'b0, 163);
    drive_bit(1'b1, 163);
    drive_bit(1'b0, 163);
    drive_bit(1'b0, 163);
    drive_bit(1'b0, 163);
    drive_bit(1'b0, 80);
    rst   = 1'b0;
    rx_in = 1'b1;
    @(negedge clock);
    check("midrst data_out",   32'(data_out),   32'h00);
    check("midrst data_valid", 32'(data_valid), 32'h0);
    check("midrst parity_err", 32'(parity_err), 32'h0);
    check("midrst frame_err",  32'(frame_err),  32'h0);
    check("midrst busy",       32'(busy),       32'h0);
    repeat (4) @(negedge clock);
    rst = 1'b1;
    vb = vcount;
    fb = fcount;
    drive_bit(1'b1, 2 * 163);
    check("midrst no pulse valid", 32'(vcount - vb), 32'd0);
    check("midrst no pulse ferr",  32'(fcount - fb), 32'd0);
    check("midrst idle busy", 32'(busy), 32'd0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 163, 1'b0);
    repeat (20) @(negedge clock);
    check("post-rst valid count", 32'(vcount - vb), 32'd1);
    check("post-rst data_out", 32'(vlog[vb[7:0]]), 32'h81);
    check("post-rst parity_err", 32'(last_perr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops in the rx_in synchronizer (legal 2..3).
REQ-002 SHALL have port clock, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; asynchronous and active-low.
REQ-004 SHALL have port rx_in, input, 1: serial line, idle high, asynchronous to clock.
REQ-005 SHALL have port baud_rate, input, 2: rate select, same encoding as the transmitter's baud_gen.
REQ-006 SHALL have port parity_en, input, 1: 1 = even parity bit expected after data.
REQ-007 SHALL have port data_out, output, 8: last received byte.
REQ-008 SHALL have port data_valid, output, 1: one-cycle pulse; data_out and parity_err valid.
REQ-009 SHALL have port parity_err, output, 1: parity mismatch on the byte flagged by data_valid.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse; stop bit sampled low.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 Frame SHALL be 1 start (0), 8 data LSB first, optional parity, 1 stop (1).
REQ-013 Bit period P in clocks SHALL be 13004/652/327/163 for baud_rate 00/01/10/11; half period H SHALL be 6502/326/163/81.
REQ-014 baud_rate and parity_en SHALL be latched at start detection and held for the whole frame.
REQ-015 rx_in SHALL pass through SYNC_STAGES flops (reset value 1); all decisions use the synchronized value.
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 IDLE -> START when synchronized line is 0; bit counter cleared.
REQ-018 START: after H clocks sample; 0 -> DATA, 1 -> IDLE (glitch rejected, no flags).
REQ-019 DATA: sample every P clocks, shift into data register LSB first; after 8th sample -> PARITY if latched parity_en, else STOP.
REQ-020 PARITY: after P clocks sample; parity_err computed as XOR of 8 data bits and sampled bit (1 = error); -> STOP.
REQ-021 STOP: after P clocks sample; 1 -> IDLE with data_valid pulse next cycle; 0 -> WAIT_HIGH with frame_err pulse next cycle, no data_valid.
REQ-022 WAIT_HIGH SHALL return to IDLE only once line is sampled 1 (break/stuck-low safe).
REQ-023 data_out and parity_err SHALL update only with data_valid and hold until the next data_valid; parity_err = 0 when parity disabled.
REQ-024 Back-to-back frames SHALL be received with no idle gap: new start detectable the cycle after returning to IDLE.
REQ-025 Baud counter SHALL be 14 bits, reload to 0 on each sample; baud_rate changes mid-frame SHALL have no effect.

Reset
REQ-026 On rst low: state IDLE, counters 0, synchronizer 1s, data_out 0x00, data_valid 0, parity_err 0, frame_err 0, busy 0.
REQ-027 Reset mid-frame SHALL abort immediately, producing no pulse after deassertion; a partially received frame is discarded.

Structure
REQ-028 State encoding and P/H constant tables SHALL live in a shared package uart_pkg, also used by baud_gen's transmitter side.
REQ-029 Synchronizer SHALL be a sub-module sync_bit; remaining logic flat in uart_rx.

Verification
REQ-030 baud_rate=11, parity off, send 0xA5 at P=163 -> data_valid once, data_out=0xA5, parity_err=0, frame_err=0.
REQ-031 baud_rate=11, parity on, send 0x07 with parity bit 0 -> data_valid, data_out=0x07, parity_err=1.
REQ-032 Low glitch of 40 clocks on idle line -> returns to IDLE, no data_valid, no frame_err.
REQ-033 Send 0x3C with stop bit 0, line held low 500 clocks -> frame_err pulse, no data_valid, busy high until line returns high.
REQ-034 Two frames 0x55 then 0xAA back-to-back at baud_rate=10 -> two data_valid pulses with those values in order.
REQ-035 Assert rst during DATA bit 4 -> all outputs at reset values; subsequent 0x81 frame received correctly.
